// File: rtl/dac_spi_frame_receiver_pkg.sv
// Shared definitions for the DAC SPI frame receiver.
// Holds the LTC2624-style command and address codes, the bit positions of the
// fields inside a 32-bit command frame, and the receiver FSM state encoding.
package dac_spi_frame_receiver_pkg;

    // Command nibble values
    localparam logic [3:0] CMD_WRITE         = 4'h0;
    localparam logic [3:0] CMD_UPDATE        = 4'h1;
    localparam logic [3:0] CMD_WRITE_UPD_ALL = 4'h2;
    localparam logic [3:0] CMD_WRITE_UPD     = 4'h3;
    localparam logic [3:0] CMD_NOP           = 4'hF;

    // Address nibble that selects every channel at once
    localparam logic [3:0] ADDR_ALL = 4'hF;

    // Frame geometry (bit 31 is shifted in first)
    localparam int SR_BITS   = 32;
    localparam int CMD_MSB   = 23;
    localparam int CMD_LSB   = 20;
    localparam int ADDR_MSB  = 19;
    localparam int ADDR_LSB  = 16;
    localparam int DATA_MSB  = 15;
    localparam int DATA_LSB  = 4;
    localparam int DATA_BITS = 12;
    localparam int NUM_CH    = 4;

    // Bit counter geometry
    localparam int CNT_BITS = 6;
    localparam int CNT_MAX  = 63;

    typedef logic [DATA_BITS-1:0] sample_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DECODE = 2'd2
    } state_t;

endpackage

// File: rtl/dac_spi_frame_receiver_sync.sv
// N-stage synchroniser plus edge detector for one asynchronous input.
// Ports:
//   clk, rst  - system clock and asynchronous active-high reset
//   din       - raw asynchronous input
//   level     - synchronised level (din itself when STAGES == 0)
//   rise/fall - one-cycle pulses on a synchronised 0->1 / 1->0 transition
// RESET_VAL lets idle-high signals (chip select, clear) come out of reset
// inactive so that reset release never looks like an edge.
module spi_input_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic prev;

    if (STAGES == 0) begin : g_bypass
        assign level = din;
    end else begin : g_sync
        logic [STAGES-1:0] chain;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                chain <= {STAGES{RESET_VAL}};
            end else begin
                chain[0] <= din;
                for (int i = 1; i < STAGES; i++) begin
                    chain[i] <= chain[i-1];
                end
            end
        end

        assign level = chain[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= RESET_VAL;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/dac_spi_frame_receiver.sv
// SPI responder for 32-bit LTC2624-style DAC command frames.
// Receives frames on SPI_SCK/SPI_MOSI/DAC_CS, decodes them and models the
// four input registers and four DAC registers of the converter so that the
// DAC write path can be checked on chip.
// Ports:
//   CLK_50M, reset          - system clock, asynchronous active-high reset
//   SPI_SCK, SPI_MOSI       - serial clock (rising edge samples) and data, MSB first
//   DAC_CS, DAC_CLR         - active-low frame select and register clear
//   frame_valid, frame_err  - one-cycle pulses for a good / malformed frame
//   last_cmd, last_addr     - command and address nibbles of the last good frame
//   dac_a .. dac_d          - DAC (output) register of each channel
module dac_spi_frame_receiver
    import dac_spi_frame_receiver_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 32
) (
    input  logic        CLK_50M,
    input  logic        reset,
    input  logic        SPI_SCK,
    input  logic        SPI_MOSI,
    input  logic        DAC_CS,
    input  logic        DAC_CLR,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [3:0]  last_cmd,
    output logic [3:0]  last_addr,
    output logic [11:0] dac_a,
    output logic [11:0] dac_b,
    output logic [11:0] dac_c,
    output logic [11:0] dac_d
);

    localparam logic [CNT_BITS-1:0] FRAME_CNT = CNT_BITS'(FRAME_BITS);

    // ---------------- input synchronisers ----------------
    logic sck, sck_rise, sck_fall;
    logic mosi, mosi_rise, mosi_fall;
    logic cs, cs_rise, cs_fall;
    logic clr_n, clr_rise, clr_fall;

    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(CLK_50M), .rst(reset), .din(SPI_SCK),
        .level(sck), .rise(sck_rise), .fall(sck_fall)
    );
    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(CLK_50M), .rst(reset), .din(SPI_MOSI),
        .level(mosi), .rise(mosi_rise), .fall(mosi_fall)
    );
    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(CLK_50M), .rst(reset), .din(DAC_CS),
        .level(cs), .rise(cs_rise), .fall(cs_fall)
    );
    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_clr (
        .clk(CLK_50M), .rst(reset), .din(DAC_CLR),
        .level(clr_n), .rise(clr_rise), .fall(clr_fall)
    );

    // ---------------- state ----------------
    state_t                state, state_next;
    logic                  start_pend, start_pend_next;
    logic [SR_BITS-1:0]    shift_reg;
    logic [CNT_BITS-1:0]   bit_cnt;
    logic                  overrun;
    sample_t               in_reg  [NUM_CH];
    sample_t               dac_reg [NUM_CH];

    logic start_frame, shift_en, decode_ok, decode_bad;

    logic [3:0] frame_cmd, frame_addr;
    sample_t    frame_data;
    assign frame_cmd  = shift_reg[CMD_MSB:CMD_LSB];
    assign frame_addr = shift_reg[ADDR_MSB:ADDR_LSB];
    assign frame_data = shift_reg[DATA_MSB:DATA_LSB];

    // Edges and frame padding that carry no information for this block.
    logic unused_bits;
    assign unused_bits = ^{sck, sck_fall, mosi_rise, mosi_fall, clr_rise, clr_fall,
                           shift_reg[SR_BITS-1:CMD_MSB+1], shift_reg[DATA_LSB-1:0]};

    // ---------------- FSM: next state ----------------
    // NOTE: every signal assigned here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_next      = state;
        start_pend_next = start_pend;
        start_frame     = 1'b0;
        shift_en        = 1'b0;
        decode_ok       = 1'b0;
        decode_bad      = 1'b0;

        if (!clr_n) begin
            // Clear aborts silently; a new frame needs a fresh CS falling edge.
            state_next      = ST_IDLE;
            start_pend_next = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs_fall || (start_pend && !cs)) begin
                        state_next      = ST_SHIFT;
                        start_frame     = 1'b1;
                        start_pend_next = 1'b0;
                    end else if (cs) begin
                        start_pend_next = 1'b0;
                    end
                end
                ST_SHIFT: begin
                    // CS release wins over a coincident SCK edge; that bit is dropped.
                    if (cs_rise) begin
                        state_next = ST_DECODE;
                    end else if (sck_rise) begin
                        shift_en = 1'b1;
                    end
                end
                ST_DECODE: begin
                    state_next = ST_IDLE;
                    if (bit_cnt == FRAME_CNT && !overrun) begin
                        decode_ok = 1'b1;
                    end else begin
                        decode_bad = 1'b1;
                    end
                    // A CS fall seen here has no edge left for IDLE to catch.
                    if (cs_fall) begin
                        start_pend_next = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // ---------------- command decode ----------------
    sample_t in_next  [NUM_CH];
    sample_t dac_next [NUM_CH];
    logic    addr_ok;

    assign addr_ok = (frame_addr < 4'd4) || (frame_addr == ADDR_ALL);

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            in_next[ch]  = in_reg[ch];
            dac_next[ch] = dac_reg[ch];
        end

        if (addr_ok) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (frame_addr == ADDR_ALL || frame_addr == 4'(ch)) begin
                    case (frame_cmd)
                        CMD_WRITE, CMD_WRITE_UPD_ALL: in_next[ch] = frame_data;
                        CMD_UPDATE:                   dac_next[ch] = in_reg[ch];
                        CMD_WRITE_UPD: begin
                            in_next[ch]  = frame_data;
                            dac_next[ch] = frame_data;
                        end
                        default: ;
                    endcase
                end
            end
            // The update-all uses the freshly written input value.
            if (frame_cmd == CMD_WRITE_UPD_ALL) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    dac_next[ch] = in_next[ch];
                end
            end
        end
    end

    // ---------------- sequential ----------------
    always_ff @(posedge CLK_50M or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            start_pend <= 1'b0;
        end else begin
            state      <= state_next;
            start_pend <= start_pend_next;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would make results depend on statement order.
    always_ff @(posedge CLK_50M or posedge reset) begin
        if (reset) begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            last_cmd    <= '0;
            last_addr   <= '0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            overrun     <= 1'b0;
            // NOTE: the register arrays are only eight 12-bit words and must read
            // as zero after reset, so they are reset like any other flop.
            for (int ch = 0; ch < NUM_CH; ch++) begin
                in_reg[ch]  <= '0;
                dac_reg[ch] <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (!clr_n) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    in_reg[ch]  <= '0;
                    dac_reg[ch] <= '0;
                end
            end else begin
                if (start_frame) begin
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                    overrun   <= 1'b0;
                end
                if (shift_en) begin
                    shift_reg <= {shift_reg[SR_BITS-2:0], mosi};
                    if (bit_cnt != CNT_BITS'(CNT_MAX)) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (bit_cnt == FRAME_CNT) begin
                        overrun <= 1'b1;
                    end
                end
                if (decode_ok) begin
                    frame_valid <= 1'b1;
                    last_cmd    <= frame_cmd;
                    last_addr   <= frame_addr;
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        in_reg[ch]  <= in_next[ch];
                        dac_reg[ch] <= dac_next[ch];
                    end
                end
                if (decode_bad) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    assign dac_a = dac_reg[0];
    assign dac_b = dac_reg[1];
    assign dac_c = dac_reg[2];
    assign dac_d = dac_reg[3];

endmodule

// File: tb/tb_dac_spi_frame_receiver.sv
// Self-checking bench for dac_spi_frame_receiver. Two instances share the
// stimulus: dut (SYNC_STAGES=2) carries the table-driven checks, dut0
// (SYNC_STAGES=0) is used for the back-to-back latency sequence.
module tb_dac_spi_frame_receiver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_sck = 1'b0;
    logic spi_mosi = 1'b0;
    logic dac_cs = 1'b1;
    logic dac_clr = 1'b1;

    logic        fv, fe, fv0, fe0;
    logic [3:0]  cmd, addr, cmd0, addr0;
    logic [11:0] da, db, dc, dd, da0, db0, dc0, dd0;

    always #10 clk = ~clk;

    dac_spi_frame_receiver #(.SYNC_STAGES(2), .FRAME_BITS(32)) dut (
        .CLK_50M(clk), .reset(rst), .SPI_SCK(spi_sck), .SPI_MOSI(spi_mosi),
        .DAC_CS(dac_cs), .DAC_CLR(dac_clr),
        .frame_valid(fv), .frame_err(fe), .last_cmd(cmd), .last_addr(addr),
        .dac_a(da), .dac_b(db), .dac_c(dc), .dac_d(dd)
    );

    dac_spi_frame_receiver #(.SYNC_STAGES(0), .FRAME_BITS(32)) dut0 (
        .CLK_50M(clk), .reset(rst), .SPI_SCK(spi_sck), .SPI_MOSI(spi_mosi),
        .DAC_CS(dac_cs), .DAC_CLR(dac_clr),
        .frame_valid(fv0), .frame_err(fe0), .last_cmd(cmd0), .last_addr(addr0),
        .dac_a(da0), .dac_b(db0), .dac_c(dc0), .dac_d(dd0)
    );

    // Pulse counters and timestamps, sampled mid-cycle
    int cyc = 0;
    int fv_cnt = 0, fe_cnt = 0, fv0_cnt = 0, fe0_cnt = 0;
    int fv0_cyc = -1000;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (fv)  fv_cnt++;
        if (fe)  fe_cnt++;
        if (fv0) begin
            fv0_cnt++;
            fv0_cyc = cyc;
        end
        if (fe0) fe0_cnt++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic shift_bits(input logic [63:0] word, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_mosi = word[i];
            repeat (2) @(negedge clk);
            spi_sck = 1'b1;
            repeat (2) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [63:0] word, input int nbits);
        @(negedge clk);
        dac_cs = 1'b0;
        repeat (4) @(negedge clk);
        shift_bits(word, nbits);
        repeat (2) @(negedge clk);
        dac_cs = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    typedef struct {
        logic [63:0] word;
        int          nbits;
        bit          clr_before;
        int          exp_fv;
        int          exp_fe;
        logic [11:0] a, b, c, d;
        logic [3:0]  cmd, addr;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int fv0s, fes, fv0_0, t1, rise1, rise2;

        vecs[0]  = '{64'h0030ABC0, 32, 1'b0, 1, 0, 12'hABC, 12'h000, 12'h000, 12'h000, 4'h3, 4'h0};
        vecs[1]  = '{64'h00015550, 32, 1'b0, 1, 0, 12'hABC, 12'h000, 12'h000, 12'h000, 4'h0, 4'h1};
        vecs[2]  = '{64'h00110000, 32, 1'b0, 1, 0, 12'hABC, 12'h555, 12'h000, 12'h000, 4'h1, 4'h1};
        vecs[3]  = '{64'h00351230, 32, 1'b0, 1, 0, 12'hABC, 12'h555, 12'h000, 12'h000, 4'h3, 4'h5};
        vecs[4]  = '{64'h00F00000, 32, 1'b0, 1, 0, 12'hABC, 12'h555, 12'h000, 12'h000, 4'hF, 4'h0};
        vecs[5]  = '{64'h0030ABC0, 31, 1'b0, 0, 1, 12'hABC, 12'h555, 12'h000, 12'h000, 4'hF, 4'h0};
        vecs[6]  = '{64'h0030ABC0, 33, 1'b0, 0, 1, 12'hABC, 12'h555, 12'h000, 12'h000, 4'hF, 4'h0};
        vecs[7]  = '{64'h003FFFF0, 32, 1'b0, 1, 0, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 4'h3, 4'hF};
        vecs[8]  = '{64'h00207770, 32, 1'b1, 1, 0, 12'h777, 12'h000, 12'h000, 12'h000, 4'h2, 4'h0};
        vecs[9]  = '{64'h00010120, 32, 1'b0, 1, 0, 12'h777, 12'h000, 12'h000, 12'h000, 4'h0, 4'h1};
        vecs[10] = '{64'h001F0000, 32, 1'b0, 1, 0, 12'h777, 12'h012, 12'h000, 12'h000, 4'h1, 4'hF};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_fv", {31'd0, fv}, 32'd0);
        check("rst_fe", {31'd0, fe}, 32'd0);
        check("rst_cmd_addr", {24'd0, cmd, addr}, 32'd0);
        check("rst_dacs", {da, db, dc, dd} == 48'd0 ? 32'd1 : 32'd0, 32'd1);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Table-driven frames
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].clr_before) begin
                fv0s = fv_cnt;
                fes  = fe_cnt;
                @(negedge clk);
                dac_clr = 1'b0;
                @(negedge clk);
                dac_clr = 1'b1;
                repeat (6) @(negedge clk);
                check("clr_a", {20'd0, da}, 32'd0);
                check("clr_b", {20'd0, db}, 32'd0);
                check("clr_c", {20'd0, dc}, 32'd0);
                check("clr_d", {20'd0, dd}, 32'd0);
                check("clr_no_pulse", 32'(fv_cnt - fv0s + fe_cnt - fes), 32'd0);
            end
            fv0s = fv_cnt;
            fes  = fe_cnt;
            send_frame(vecs[i].word, vecs[i].nbits);
            check($sformatf("v%0d_fv", i), 32'(fv_cnt - fv0s), 32'(vecs[i].exp_fv));
            check($sformatf("v%0d_fe", i), 32'(fe_cnt - fes), 32'(vecs[i].exp_fe));
            check($sformatf("v%0d_a", i), {20'd0, da}, {20'd0, vecs[i].a});
            check($sformatf("v%0d_b", i), {20'd0, db}, {20'd0, vecs[i].b});
            check($sformatf("v%0d_c", i), {20'd0, dc}, {20'd0, vecs[i].c});
            check($sformatf("v%0d_d", i), {20'd0, dd}, {20'd0, vecs[i].d});
            check($sformatf("v%0d_cmd", i), {28'd0, cmd}, {28'd0, vecs[i].cmd});
            check($sformatf("v%0d_addr", i), {28'd0, addr}, {28'd0, vecs[i].addr});
        end

        // Reset in the middle of a frame (after 16 bits)
        fv0s = fv_cnt;
        fes  = fe_cnt;
        @(negedge clk);
        dac_cs = 1'b0;
        repeat (4) @(negedge clk);
        shift_bits(64'h0030ABC0 >> 16, 16);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_a", {20'd0, da}, 32'd0);
        check("midrst_b", {20'd0, db}, 32'd0);
        check("midrst_cmd_addr", {24'd0, cmd, addr}, 32'd0);
        dac_cs = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_no_pulse", 32'(fv_cnt - fv0s + fe_cnt - fes), 32'd0);
        send_frame(64'h00321230, 32);
        check("post_rst_c", {20'd0, dc}, 32'h123);
        check("post_rst_a", {20'd0, da}, 32'd0);
        check("post_rst_cmd_addr", {24'd0, cmd, addr}, 32'h32);

        // Back-to-back frames with a one-cycle CS high gap
        fv0s  = fv_cnt;
        fv0_0 = fv0_cnt;
        fes   = fe_cnt + fe0_cnt;
        @(negedge clk);
        dac_cs = 1'b0;
        repeat (4) @(negedge clk);
        shift_bits(64'h00300110, 32);
        repeat (2) @(negedge clk);
        dac_cs = 1'b1;
        rise1 = cyc;
        @(negedge clk);
        dac_cs = 1'b0;
        repeat (4) @(negedge clk);
        t1 = fv0_cyc;
        shift_bits(64'h00310220, 32);
        repeat (2) @(negedge clk);
        dac_cs = 1'b1;
        rise2 = cyc;
        repeat (10) @(negedge clk);
        check("b2b_lat1", 32'(t1 - rise1), 32'd2);
        check("b2b_lat2", 32'(fv0_cyc - rise2), 32'd2);
        check("b2b_fv0", 32'(fv0_cnt - fv0_0), 32'd2);
        check("b2b_fv", 32'(fv_cnt - fv0s), 32'd2);
        check("b2b_no_err", 32'(fe_cnt + fe0_cnt - fes), 32'd0);
        check("b2b_a0", {20'd0, da0}, 32'h011);
        check("b2b_b0", {20'd0, db0}, 32'h022);
        check("b2b_a", {20'd0, da}, 32'h011);
        check("b2b_b", {20'd0, db}, 32'h022);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
